// File: rtl/agusec_pkg.sv
// Shared definitions for the AGU pointer-security bounds-check scheduler:
// tagged-pointer layout, operand width and fault-counter helpers.
package agusec_pkg;

    localparam int PTR_W  = 64;
    localparam int OPND_W = 40;
    localparam int FCNT_W = 16;

    // Tagged pointer: exponent, upper/lower bound fields, low-half flag, address.
    typedef struct packed {
        logic [5:0]  ptr_exp;
        logic [7:0]  ptr_hi;
        logic [7:0]  ptr_low;
        logic        ptr_on_low;
        logic [40:0] addr;
    } ptr_t;

    localparam logic [FCNT_W-1:0] FCNT_MAX = '1;

    function automatic logic [FCNT_W-1:0] fcnt_inc(input logic [FCNT_W-1:0] c);
        return (c == FCNT_MAX) ? c : c + FCNT_W'(1);
    endfunction

endpackage

// File: rtl/agusec_rr_arb.sv
// Rotating-priority arbiter: one-hot grant to the first requester at or
// above the priority pointer, wrapping at NREQ-1.
module agusec_rr_arb #(
    parameter int  NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   rr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    int idx;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        idx   = 0;
        if (en_i) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_i) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!any_o && req_i[idx]) begin
                    gnt_o[idx] = 1'b1;
                    idx_o      = PW'(idx);
                    any_o      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/agusec_sched.sv
// Scheduler sharing one external bounds-check unit among NREQ AGU ports:
// round-robin grant -> S1 check stage -> S2 result stage, with flush and fault count.
module agusec_sched
    import agusec_pkg::*;
#(
    parameter int  NREQ = 4,
    parameter int  TAGW = 6,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_vld,
    output logic [NREQ-1:0]        req_rdy,
    input  logic [NREQ*PTR_W-1:0]  req_ptr,
    input  logic [NREQ*OPND_W-1:0] req_a,
    input  logic [NREQ*OPND_W-1:0] req_b,
    input  logic [NREQ*TAGW-1:0]   req_tag,
    input  logic                   sec_en,
    input  logic                   flush,
    output logic [PTR_W-1:0]       chk_ptr,
    output logic [OPND_W-1:0]      chk_a,
    output logic [OPND_W-1:0]      chk_b,
    input  logic                   chk_ok,
    output logic                   res_vld,
    input  logic                   res_stall,
    output logic [PW-1:0]          res_port,
    output logic [TAGW-1:0]        res_tag,
    output logic                   res_fault,
    output logic [FCNT_W-1:0]      fault_cnt
);

    logic              s1_vld_q, s1_vld_d;
    ptr_t              s1_ptr_q, s1_ptr_d;
    logic [OPND_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [TAGW-1:0]   s1_tag_q, s1_tag_d;
    logic [PW-1:0]     s1_port_q, s1_port_d;

    logic              s2_vld_q, s2_vld_d;
    logic              s2_fault_q, s2_fault_d;
    logic [TAGW-1:0]   s2_tag_q, s2_tag_d;
    logic [PW-1:0]     s2_port_q, s2_port_d;

    logic [PW-1:0]     rr_q, rr_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    logic              adv1, adv2;
    logic [NREQ-1:0]   gnt;
    logic [PW-1:0]     gnt_idx;
    logic              gnt_any;

    assign adv2 = ~s2_vld_q | ~res_stall;
    assign adv1 = ~s1_vld_q | adv2;

    agusec_rr_arb #(.NREQ(NREQ)) u_arb (
        .req_i (req_vld),
        .rr_i  (rr_q),
        .en_i  (adv1 & ~flush & ~rst),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign req_rdy = gnt;

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_ptr_d   = s1_ptr_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        s1_port_d  = s1_port_q;
        s2_vld_d   = s2_vld_q;
        s2_fault_d = s2_fault_q;
        s2_tag_d   = s2_tag_q;
        s2_port_d  = s2_port_q;
        rr_d       = rr_q;
        fcnt_d     = fcnt_q;

        if (flush) begin
            // Flush drops both stages; a result sitting in S2 is never counted.
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end else begin
            if (s2_vld_q && !res_stall && s2_fault_q) begin
                fcnt_d = fcnt_inc(fcnt_q);
            end
            if (adv2) begin
                s2_vld_d = s1_vld_q;
                s1_vld_d = 1'b0;
                if (s1_vld_q) begin
                    s2_fault_d = sec_en & ~chk_ok;
                    s2_tag_d   = s1_tag_q;
                    s2_port_d  = s1_port_q;
                end
            end
            if (gnt_any) begin
                s1_vld_d  = 1'b1;
                s1_ptr_d  = ptr_t'(req_ptr[int'(gnt_idx)*PTR_W +: PTR_W]);
                s1_a_d    = req_a[int'(gnt_idx)*OPND_W +: OPND_W];
                s1_b_d    = req_b[int'(gnt_idx)*OPND_W +: OPND_W];
                s1_tag_d  = req_tag[int'(gnt_idx)*TAGW +: TAGW];
                s1_port_d = gnt_idx;
                rr_d      = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_ptr_q   <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
            s1_port_q  <= '0;
            s2_vld_q   <= 1'b0;
            s2_fault_q <= 1'b0;
            s2_tag_q   <= '0;
            s2_port_q  <= '0;
            rr_q       <= '0;
            fcnt_q     <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_ptr_q   <= s1_ptr_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_tag_q   <= s1_tag_d;
            s1_port_q  <= s1_port_d;
            s2_vld_q   <= s2_vld_d;
            s2_fault_q <= s2_fault_d;
            s2_tag_q   <= s2_tag_d;
            s2_port_q  <= s2_port_d;
            rr_q       <= rr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign chk_ptr   = s1_ptr_q;
    assign chk_a     = s1_a_q;
    assign chk_b     = s1_b_q;
    assign res_vld   = s2_vld_q;
    assign res_fault = s2_fault_q;
    assign res_tag   = s2_tag_q;
    assign res_port  = s2_port_q;
    assign fault_cnt = fcnt_q;

endmodule
